// File: rtl/irrigation_timer_display.sv
// BCD countdown irrigation timer with a multiplexed 7-segment display.
// Optional build macro: IRRIGATION_TIMER_LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module irrigation_timer_display #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 32051
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  error,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  running,
    output logic                  done,
    output logic                  err_flag,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int IDX_W  = $clog2(DIGITS);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     digit_en_q, digit_en_d;
    logic                  tick;
    logic [4*DIGITS-1:0]   dec_value;
    logic [3:0]            shown_digit;

    function automatic logic [4*DIGITS-1:0] saturate(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Borrow ripples upward: a zero digit wraps to 9 and keeps borrowing.
    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign running  = (state_q == ST_RUN) && !pause;
    assign done     = (state_q == ST_DONE);
    assign err_flag = (state_q == ST_ERR);
    assign bcd_out  = value_q;
    assign seg      = seg_q;
    assign digit_en = digit_en_q;

    assign tick      = running && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign dec_value = bcd_dec(value_q);

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        tick_cnt_d = tick_cnt_q;
        if (error) begin
            state_d = ST_ERR;
        end else if (load) begin
            state_d    = ST_IDLE;
            value_d    = saturate(preset);
            tick_cnt_d = '0;
        end else if (state_q == ST_ERR) begin
            state_d = ST_ERR;
        end else if (start && state_q == ST_IDLE) begin
            state_d    = (value_q != '0) ? ST_RUN : ST_DONE;
            tick_cnt_d = '0;
        end else if (running) begin
            if (tick) begin
                value_d    = dec_value;
                tick_cnt_d = '0;
                if (dec_value == '0) state_d = ST_DONE;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // Display is decoded from next-state values so seg always matches the registered contents.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        shown_digit = value_d[{idx_d, 2'b00} +: 4];
        digit_en_d  = ~(DIGITS'(1) << idx_d);
        if (state_d == ST_ERR) begin
            seg_d = 7'b1000000;
        end else begin
            seg_d = seg_decode(shown_digit);
`ifdef IRRIGATION_TIMER_LEADING_ZERO_BLANK_EN
            begin
                logic blank;
                blank = (idx_d != '0);
                for (int i = 0; i < DIGITS; i++) begin
                    if (i >= int'(idx_d) && value_d[4*i +: 4] != 4'd0) blank = 1'b0;
                end
                if (blank) seg_d = 7'b0000000;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 7'b0111111;
            digit_en_q <= ~DIGITS'(1);
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
        end
    end

endmodule

// File: tb/tb_irrigation_timer_display.sv
// Directed bench for irrigation_timer_display (DIGITS=2, TICK_DIV=4, SCAN_DIV=3).
// Expected blanking follows IRRIGATION_TIMER_LEADING_ZERO_BLANK_EN when defined.
module tb_irrigation_timer_display;

    logic       clock = 1'b0;
    logic       rst, load, start, pause, error;
    logic [7:0] preset;
    logic [7:0] bcd_out;
    logic       running, done, err_flag;
    logic [6:0] seg;
    logic [1:0] digit_en;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic       load;
        logic [7:0] preset;
        logic       start;
        logic       error;
        logic [7:0] exp_bcd;
        logic       exp_run;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    vec_t vecs [10];

    irrigation_timer_display #(
        .DIGITS  (2),
        .TICK_DIV(4),
        .SCAN_DIV(3)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .load    (load),
        .preset  (preset),
        .start   (start),
        .pause   (pause),
        .error   (error),
        .bcd_out (bcd_out),
        .running (running),
        .done    (done),
        .err_flag(err_flag),
        .seg     (seg),
        .digit_en(digit_en)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        load   = v.load;
        preset = v.preset;
        start  = v.start;
        error  = v.error;
        step();
        load  = 1'b0;
        start = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [6:0] tens_zero_seg();
`ifdef IRRIGATION_TIMER_LEADING_ZERO_BLANK_EN
        return 7'b0000000;
`else
        return 7'b0111111;
`endif
    endfunction

    initial begin
        vecs[0] = '{1'b1, 8'hFA, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h3B, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h39, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h39, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; error = 1'b0; preset = 8'h00;
        step();
        step();
        rst = 1'b0;
        check_output("rst_bcd", 32'(bcd_out), 32'h00);
        check_output("rst_flags", {running, done, err_flag}, 3'b000);
        check_output("rst_digit_en", 32'(digit_en), 2'b10);
        check_output("rst_seg", 32'(seg), 7'b0111111);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            error = 1'b0;
            check_output($sformatf("vec%0d_bcd", i), 32'(bcd_out), 32'(vecs[i].exp_bcd));
            check_output($sformatf("vec%0d_flags", i), {running, done, err_flag},
                         {vecs[i].exp_run, vecs[i].exp_done, vecs[i].exp_err});
        end

        // Full countdown from 12
        load = 1'b1; preset = 8'h12; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check_output("cd_start_bcd", 32'(bcd_out), 32'h12);
        check_output("cd_start_run", 32'(running), 1);
        for (int v = 11; v >= 0; v--) begin
            repeat (3) step();
            check_output($sformatf("cd_hold_%0d", v), 32'(bcd_out), 32'(to_bcd(v + 1)));
            check_output($sformatf("cd_notdone_%0d", v), 32'(done), 0);
            step();
            check_output($sformatf("cd_val_%0d", v), 32'(bcd_out), 32'(to_bcd(v)));
        end
        check_output("cd_done", {running, done}, 2'b01);

        // Pause mid-count from 10 with the divider at 2
        load = 1'b1; preset = 8'h10; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
        step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_output($sformatf("pause_bcd_%0d", i), 32'(bcd_out), 32'h10);
            check_output($sformatf("pause_run_%0d", i), 32'(running), 0);
        end
        pause = 1'b0;
        step();
        check_output("resume_hold", 32'(bcd_out), 32'h10);
        step();
        check_output("resume_tick", 32'(bcd_out), 32'h09);
        repeat (3) step();
        check_output("resume_hold2", 32'(bcd_out), 32'h09);
        step();
        check_output("resume_08", 32'(bcd_out), 32'h08);
        repeat (4) step();
        check_output("reach_07", 32'(bcd_out), 32'h07);

        // Error at 07
        error = 1'b1;
        step();
        check_output("err_flag", {running, done, err_flag}, 3'b001);
        check_output("err_bcd", 32'(bcd_out), 32'h07);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("err_seg_%0d", i), 32'(seg), 7'b1000000);
            step();
        end
        load = 1'b1; preset = 8'h05; step(); load = 1'b0;
        check_output("err_load_ignored", {24'(bcd_out), 8'(err_flag)}, {24'h07, 8'h01});
        error = 1'b0; step();
        check_output("err_stays", 32'(err_flag), 1);
        load = 1'b1; preset = 8'h05; step(); load = 1'b0;
        check_output("err_exit_bcd", 32'(bcd_out), 32'h05);
        check_output("err_exit_flags", {running, done, err_flag}, 3'b000);

        // Digit scan with value 05
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) begin
                load = 1'b1; preset = 8'h05;
            end
            step();
            load = 1'b0;
            if (((i / 3) % 2) == 0) begin
                check_output($sformatf("scan_en_%0d", i), 32'(digit_en), 2'b10);
                check_output($sformatf("scan_seg_%0d", i), 32'(seg), 7'b1101101);
            end else begin
                check_output($sformatf("scan_en_%0d", i), 32'(digit_en), 2'b01);
                check_output($sformatf("scan_seg_%0d", i), 32'(seg), 32'(tens_zero_seg()));
            end
        end

        // Reset during RUN at 33, with error also high
        load = 1'b1; preset = 8'h33; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();
        check_output("pre_rst_run", {24'(bcd_out), 8'(running)}, {24'h33, 8'h01});
        rst = 1'b1; error = 1'b1; step(); rst = 1'b0; error = 1'b0;
        check_output("midrst_bcd", 32'(bcd_out), 32'h00);
        check_output("midrst_flags", {running, done, err_flag}, 3'b000);
        check_output("midrst_digit_en", 32'(digit_en), 2'b10);
        check_output("midrst_seg", 32'(seg), 7'b0111111);
        start = 1'b1; step(); start = 1'b0;
        check_output("midrst_idle_start", {running, done}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
